// File: rtl/dfi_rd_sched_if.sv
// dfi_rd_sched_if: read-command handshake plus DFI read-data enable/valid bundle
//   master: drives rd_cmd_valid_i/rd_cmd_phase_i and dfi_rddata_valid_w0..w3
//           (controller/PHY side), observes rd_cmd_ready_o and dfi_rddata_en_p0..p3
//   slave : the scheduler, the mirror image
interface dfi_rd_sched_if;
  logic       rd_cmd_valid_i;
  logic [1:0] rd_cmd_phase_i;
  logic       rd_cmd_ready_o;
  logic       dfi_rddata_en_p0, dfi_rddata_en_p1, dfi_rddata_en_p2, dfi_rddata_en_p3;
  logic       dfi_rddata_valid_w0, dfi_rddata_valid_w1, dfi_rddata_valid_w2, dfi_rddata_valid_w3;
  modport master(
    output rd_cmd_valid_i, rd_cmd_phase_i,
    output dfi_rddata_valid_w0, dfi_rddata_valid_w1, dfi_rddata_valid_w2, dfi_rddata_valid_w3,
    input  rd_cmd_ready_o,
    input  dfi_rddata_en_p0, dfi_rddata_en_p1, dfi_rddata_en_p2, dfi_rddata_en_p3
  );
  modport slave(
    input  rd_cmd_valid_i, rd_cmd_phase_i,
    input  dfi_rddata_valid_w0, dfi_rddata_valid_w1, dfi_rddata_valid_w2, dfi_rddata_valid_w3,
    output rd_cmd_ready_o,
    output dfi_rddata_en_p0, dfi_rddata_en_p1, dfi_rddata_en_p2, dfi_rddata_en_p3
  );
endinterface

// File: rtl/dfi_rd_sched.sv
// dfi_rd_sched: schedules DFI rddata_en bursts TRDDATA_EN clocks after read accept
//   dfi_clk/reset_i : clock, synchronous active-high reset
//   bus             : command handshake, per-phase enables, per-word valids
//   err_clr_i       : clears sticky errors
//   outstanding_o   : beats enabled but not yet returned
//   rd_idle_o       : nothing scheduled and nothing outstanding
//   timeout_err_o   : sticky read-latency timeout
//   underflow_err_o : sticky valid-without-outstanding-beat
module dfi_rd_sched #(
  parameter int TRDDATA_EN   = 3,
  parameter int RD_BURST_CYC = 2,
  parameter int MAX_BEATS    = 32,
  parameter int TIMEOUT      = 16,
  parameter int CNT_W        = 6
) (
  input  logic             dfi_clk,
  input  logic             reset_i,
  dfi_rd_sched_if.slave    bus,
  input  logic             err_clr_i,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             rd_idle_o,
  output logic             timeout_err_o,
  output logic             underflow_err_o
);
  localparam int BEATS = RD_BURST_CYC * 4;
  localparam int SLOTS = (TRDDATA_EN + RD_BURST_CYC) * 4;
  localparam int B0    = (TRDDATA_EN - 1) * 4;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [SLOTS-1:0] BURST = SLOTS'({BEATS{1'b1}});
  localparam logic [TMR_W-1:0] TMO   = TMR_W'(TIMEOUT);
  // r_s bit i = enable owed on phase i of the global phase stream, bits 3:0 = now
  logic [SLOTS-1:0] r_s, w_shift, w_mask;
  logic [CNT_W-1:0] r_out;
  logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
  logic             r_to, r_uf;
  logic [3:0]       w_vld;
  logic [2:0]       w_inc, w_dec;
  logic [CNT_W:0]   w_sum, w_dec_x;
  logic             w_overlap, w_full, w_acc, w_under, w_stall, w_to_set;
  assign w_vld = {bus.dfi_rddata_valid_w3, bus.dfi_rddata_valid_w2,
                  bus.dfi_rddata_valid_w1, bus.dfi_rddata_valid_w0};
  assign w_shift = r_s >> 4;
  assign w_mask = BURST << (B0 + int'(bus.rd_cmd_phase_i));
  assign w_overlap = |(w_shift & w_mask);
  // capacity counts beats already enabled plus everything still in the schedule
  assign w_full = int'(r_out) + $countones(r_s) + BEATS > MAX_BEATS;
  assign bus.rd_cmd_ready_o = !reset_i && !w_overlap && !w_full;
  assign w_acc = bus.rd_cmd_valid_i && bus.rd_cmd_ready_o;
  assign w_inc = 3'($countones(r_s[3:0]));
  assign w_dec = 3'($countones(w_vld));
  assign w_sum = {1'b0, r_out} + {{(CNT_W-2){1'b0}}, w_inc};
  assign w_dec_x = {{(CNT_W-2){1'b0}}, w_dec};
  assign w_under = w_dec_x > w_sum;
  assign w_stall = r_out != '0 && w_vld == '0;
  assign w_tmr_nxt = !w_stall ? '0 : r_tmr == TMO ? r_tmr : r_tmr + 1'b1;
  // fire only on the transition into saturation so a clear is not re-set by a held stall
  assign w_to_set = w_tmr_nxt == TMO && r_tmr != TMO;
  always_ff @(posedge dfi_clk) begin
    if (reset_i) begin
      r_s   <= '0;
      r_out <= '0;
      r_tmr <= '0;
      r_to  <= 1'b0;
      r_uf  <= 1'b0;
    end else begin
      r_s   <= w_shift | (w_acc ? w_mask : '0);
      r_out <= w_under ? '0 : CNT_W'(w_sum - w_dec_x);
      r_tmr <= w_tmr_nxt;
      r_to  <= w_to_set || (r_to && !err_clr_i);
      r_uf  <= w_under || (r_uf && !err_clr_i);
    end
  end
  assign bus.dfi_rddata_en_p0 = r_s[0];
  assign bus.dfi_rddata_en_p1 = r_s[1];
  assign bus.dfi_rddata_en_p2 = r_s[2];
  assign bus.dfi_rddata_en_p3 = r_s[3];
  assign outstanding_o   = r_out;
  assign rd_idle_o       = r_s == '0 && r_out == '0;
  assign timeout_err_o   = r_to;
  assign underflow_err_o = r_uf;
endmodule

// File: tb/tb_dfi_rd_sched.sv
// tb_dfi_rd_sched: vector table of single reads per phase, enable scoreboard, hand-written corner sequences
module tb_dfi_rd_sched;
  typedef struct { logic [1:0] ph; logic [3:0] e0, e1, e2; } vec_t;
  typedef struct { int c; logic [3:0] m; } sb_t;
  logic clk = 0, rst = 1, err_clr = 0;
  logic [5:0] outst;
  logic idle, to, uf;
  logic [3:0] en;
  int checks = 0, failures = 0, cyc = 0, acc = 0;
  vec_t vt[4];
  sb_t sb[$];
  dfi_rd_sched_if bus();
  dfi_rd_sched dut (
    .dfi_clk(clk), .reset_i(rst), .bus(bus), .err_clr_i(err_clr),
    .outstanding_o(outst), .rd_idle_o(idle), .timeout_err_o(to), .underflow_err_o(uf)
  );
  assign en = {bus.dfi_rddata_en_p3, bus.dfi_rddata_en_p2, bus.dfi_rddata_en_p1, bus.dfi_rddata_en_p0};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic vld(logic [3:0] w);
    {bus.dfi_rddata_valid_w3, bus.dfi_rddata_valid_w2, bus.dfi_rddata_valid_w1, bus.dfi_rddata_valid_w0} = w;
  endtask
  task automatic do_reset();
    tick();
    rst = 1;
    tick();
    rst = 0;
  endtask
  // enable scoreboard: each accept pushes its 8 beats at their absolute cycle/phase
  always @(negedge clk) begin
    logic [3:0] e;
    int g;
    e = '0;
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].c == cyc) begin
        e |= sb[i].m;
        sb.delete(i);
      end
    chk("en_sb", int'(en), int'(e));
    if (rst) sb.delete();
    else if (bus.rd_cmd_valid_i && bus.rd_cmd_ready_o)
      for (int k = 0; k < 8; k++) begin
        g = (cyc + 3) * 4 + int'(bus.rd_cmd_phase_i) + k;
        sb.push_back('{g / 4, 4'(1 << (g % 4))});
      end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vt[0] = '{2'd0, 4'hF, 4'hF, 4'h0};
    vt[1] = '{2'd1, 4'hE, 4'hF, 4'h1};
    vt[2] = '{2'd2, 4'hC, 4'hF, 4'h3};
    vt[3] = '{2'd3, 4'h8, 4'hF, 4'h7};
    bus.rd_cmd_valid_i = 0;
    bus.rd_cmd_phase_i = 0;
    vld(4'h0);
    tick();
    @(negedge clk);
    chk("ready_in_rst", int'(bus.rd_cmd_ready_o), 0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("rst_ready", int'(bus.rd_cmd_ready_o), 1);
    chk("rst_idle", int'(idle), 1);
    chk("rst_outst", int'(outst), 0);
    chk("rst_to", int'(to), 0);
    chk("rst_uf", int'(uf), 0);
    foreach (vt[r]) begin
      tick();
      bus.rd_cmd_valid_i = 1;
      bus.rd_cmd_phase_i = vt[r].ph;
      @(negedge clk);
      chk("vec_ready", int'(bus.rd_cmd_ready_o), 1);
      tick();
      bus.rd_cmd_valid_i = 0;
      @(negedge clk);
      chk("vec_busy", int'(idle), 0);
      tick();
      tick();
      @(negedge clk);
      chk("vec_en0", int'(en), int'(vt[r].e0));
      tick();
      @(negedge clk);
      chk("vec_en1", int'(en), int'(vt[r].e1));
      tick();
      @(negedge clk);
      chk("vec_en2", int'(en), int'(vt[r].e2));
      tick();
      vld(4'hF);
      @(negedge clk);
      chk("vec_outst8", int'(outst), 8);
      tick();
      @(negedge clk);
      chk("vec_outst4", int'(outst), 4);
      tick();
      vld(4'h0);
      @(negedge clk);
      chk("vec_outst0", int'(outst), 0);
      chk("vec_idle", int'(idle), 1);
      chk("vec_uf", int'(uf), 0);
      chk("vec_to", int'(to), 0);
    end
    // back-to-back: second request blocked by overlap for one cycle, then seamless
    tick();
    bus.rd_cmd_valid_i = 1;
    bus.rd_cmd_phase_i = 0;
    @(negedge clk);
    chk("b2b_ready0", int'(bus.rd_cmd_ready_o), 1);
    tick();
    @(negedge clk);
    chk("b2b_ovl", int'(bus.rd_cmd_ready_o), 0);
    tick();
    @(negedge clk);
    chk("b2b_ready2", int'(bus.rd_cmd_ready_o), 1);
    tick();
    bus.rd_cmd_valid_i = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_en", int'(en), 15);
      tick();
    end
    vld(4'hF);
    @(negedge clk);
    chk("b2b_outst16", int'(outst), 16);
    repeat (4) tick();
    vld(4'h0);
    @(negedge clk);
    chk("b2b_outst0", int'(outst), 0);
    chk("b2b_idle", int'(idle), 1);
    // latency timeout and sticky clear
    tick();
    bus.rd_cmd_valid_i = 1;
    bus.rd_cmd_phase_i = 0;
    tick();
    bus.rd_cmd_valid_i = 0;
    repeat (18) tick();
    @(negedge clk);
    chk("to_before", int'(to), 0);
    tick();
    @(negedge clk);
    chk("to_set", int'(to), 1);
    repeat (4) tick();
    @(negedge clk);
    chk("to_sticky", int'(to), 1);
    tick();
    err_clr = 1;
    @(negedge clk);
    chk("to_clr_same", int'(to), 1);
    tick();
    err_clr = 0;
    @(negedge clk);
    chk("to_cleared", int'(to), 0);
    chk("to_outst", int'(outst), 8);
    do_reset();
    // capacity: four non-overlapping reads fill the 32-beat cap
    bus.rd_cmd_valid_i = 1;
    bus.rd_cmd_phase_i = 0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rd_cmd_ready_o) acc++;
      tick();
    end
    @(negedge clk);
    chk("cap_ready", int'(bus.rd_cmd_ready_o), 0);
    chk("cap_accepts", acc, 4);
    bus.rd_cmd_valid_i = 0;
    do_reset();
    // underflow on a valid with nothing outstanding
    vld(4'h1);
    tick();
    vld(4'h0);
    @(negedge clk);
    chk("uf_set", int'(uf), 1);
    chk("uf_outst", int'(outst), 0);
    // reset in the middle of a burst
    tick();
    bus.rd_cmd_valid_i = 1;
    bus.rd_cmd_phase_i = 0;
    tick();
    bus.rd_cmd_valid_i = 0;
    tick();
    tick();
    rst = 1;
    @(negedge clk);
    chk("mid_en", int'(en), 15);
    chk("mid_uf_held", int'(uf), 1);
    chk("mid_ready_rst", int'(bus.rd_cmd_ready_o), 0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("mid_en_off", int'(en), 0);
    chk("mid_outst", int'(outst), 0);
    chk("mid_uf", int'(uf), 0);
    chk("mid_to", int'(to), 0);
    chk("mid_idle", int'(idle), 1);
    repeat (6) tick();
    @(negedge clk);
    chk("mid_quiet", int'(en), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dfi_rd_sched.md
Name: dfi_rd_sched

Overview:
- Read-data-enable scheduler between the memory-controller read issue path and the DFI read-data interface of the LPDDR PHY.
- Accepts read commands tagged with a DFI phase and drives dfi_rddata_en_p0..p3 so each burst starts exactly trddata_en DFI clocks later.
- Rejects commands that would overlap a scheduled burst, tracks beats still owed by dfi_rddata_valid_w0..w3, and flags read-latency timeout and valid underflow.

Parameters:
TRDDATA_EN, 3, DFI clocks from command accept to first rddata_en phase (legal range 1..15)
RD_BURST_CYC, 2, DFI clocks of rddata_en per read; each read = RD_BURST_CYC*4 phase beats
MAX_BEATS, 32, cap on outstanding beats plus scheduled beats
TIMEOUT, 16, consecutive stalled cycles before timeout error
CNT_W, 6, width of the outstanding-beat counter; must satisfy 2^CNT_W > MAX_BEATS

Ports:
dfi_clk  in  1  DFI clock, all logic on rising edge
reset_i  in  1  synchronous, active-high reset
rd_cmd_valid_i  in  1  read command request
rd_cmd_phase_i  in  2  DFI phase (0..3) where the burst starts
rd_cmd_ready_o  out  1  command accepted when valid&ready
dfi_rddata_en_p0..p3  out  1 each  read data enable per phase, registered
dfi_rddata_valid_w0..w3  in  1 each  returned-data valid per word
err_clr_i  in  1  clears sticky errors
outstanding_o  out  CNT_W  beats enabled but not yet returned
rd_idle_o  out  1  nothing scheduled and outstanding_o==0
timeout_err_o  out  1  sticky latency-timeout flag
underflow_err_o  out  1  sticky flag for valid with no outstanding beat

Behaviour:
- Reset (synchronous, any time, including mid-burst):
  - schedule register S cleared; all dfi_rddata_en_pX = 0.
  - outstanding_o = 0, timer = 0, both errors = 0, rd_idle_o = 1.
  - rd_cmd_ready_o = 1, subject to the combinational rules below.
- Schedule register S:
  - Width SLOTS = (TRDDATA_EN+RD_BURST_CYC)*4 bits.
  - dfi_rddata_en_pK = S[K].
  - Each cycle: S <= (S >> 4) | P.
  - P = 0 unless a command is accepted. On accept with phase X, P has bits set at positions B..B+RD_BURST_CYC*4-1, where B = (TRDDATA_EN-1)*4+X.
  - Accept in cycle T with phase X → enables start in cycle T+TRDDATA_EN at phase X and run RD_BURST_CYC*4 contiguous phases, wrapping into following cycles.
- rd_cmd_ready_o (combinational; depends on rd_cmd_phase_i, never on rd_cmd_valid_i):
  - Low if (S >> 4) has any bit set in positions B..B+RD_BURST_CYC*4-1 (overlap), else
  - Low if outstanding_o + popcount(S) + RD_BURST_CYC*4 > MAX_BEATS, else
  - High.
  - Low when reset_i is high.
- Outstanding counter:
  - next = outstanding + popcount(en p0..p3 this cycle) - popcount(valid w0..w3 this cycle).
  - Increment and decrement apply in the same cycle.
  - If the decrement exceeds (outstanding + increment): counter goes to 0 and underflow_err_o is set.
- Timer:
  - Increments when outstanding_o != 0 and no valid bit is high.
  - Cleared otherwise.
  - Saturates at TIMEOUT.
  - When the timer reaches TIMEOUT, timeout_err_o is set; this happens the cycle after TIMEOUT stalled cycles.
- Sticky errors:
  - Held until err_clr_i or reset.
  - If err_clr_i and a new set condition occur in the same cycle, the set wins.
  - Errors never block command acceptance.
- rd_idle_o = (S==0) && (outstanding_o==0), registered-equivalent; derived from registers only.

Test Plan:
1. Single read, phase 0, accepted cycle 10 → en_p0..p3 all high in cycles 13 and 14, low at 15; outstanding_o = 4 at cycle 14, 8 at cycle 15; rd_idle_o = 0 from cycle 11.
2. Single read, phase 2, accepted cycle 10 → cycle 13: p2,p3; cycle 14: p0..p3; cycle 15: p0,p1; total 8 beats; outstanding_o = 8 at cycle 16.
3. Phase-0 read accepted cycle 10, second phase-0 request held from cycle 11 → ready = 0 in cycle 11, 1 in cycle 12; accepted cycle 12; enables continuous across cycles 13–16 with no gap or overlap.
4. After scenario 1, drive 8 valid beats (w0..w3 high in cycles 20 and 21) → outstanding_o = 4 at cycle 21, 0 at cycle 22; rd_idle_o = 1 at cycle 22; no errors.
5. Scenario 1 with no valid ever → timer stalls cycles 14..29; timeout_err_o = 1 at cycle 30 and stays high; err_clr_i at cycle 35 → 0 at cycle 36.
6. Capacity and reset:
   - Four phase-0 reads accepted back-to-back where non-overlapping, with no returns → the fifth request sees ready = 0 (32-beat cap).
   - valid_w0 pulse with outstanding_o = 0 → underflow_err_o = 1 and counter stays 0.
   - reset_i mid-burst → next cycle all enables 0, outstanding_o = 0, errors 0.
